// File: rtl/sc_io_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sc_io_pkg
// Brief   : Shared constants, FSM encoding and 7-segment decode for the
//           sc_computer output-port display path.
// Revision: 1.0 - initial release
// ============================================================================
package sc_io_pkg;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  localparam int NPORTS = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Decimal digits needed for a W-bit value: ceil((W+1)/3.32).
  function automatic int bcd_digits(input int w);
    return ((w + 1) * 100 + 331) / 332;
  endfunction

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : bin2bcd_seq
// Brief   : Iterative double-dabble converter, one bit per cycle, BIN_W cycles.
// Revision: 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
  parameter int BIN_W = 8,
  parameter int BCD_W = 12
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [BIN_W-1:0] din,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] r_shreg;
  logic [BCD_W-1:0] r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic [BCD_W-1:0] w_adj;
  logic             w_unused;

  for (genvar n = 0; n < BCD_W / 4; n++) begin : g_nib
    assign w_adj[4*n +: 4] = (r_bcd[4*n +: 4] >= 4'd5) ? r_bcd[4*n +: 4] + 4'd3
                                                       : r_bcd[4*n +: 4];
  end

  // The top nibble's MSB is shifted out; it is zero for any legal BIN_W.
  assign w_unused = w_adj[BCD_W-1];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_shreg  <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (start) begin
      r_shreg  <= din;
      r_bcd    <= '0;
      r_cnt    <= CNT_W'(BIN_W);
      r_active <= 1'b1;
    end else if (r_active) begin
      {r_bcd, r_shreg} <= {w_adj[BCD_W-2:0], r_shreg, 1'b0};
      r_cnt            <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_active <= 1'b0;
      end
    end
  end

  // High during the final shift cycle so the caller can commit on the next one.
  assign done = r_active && (r_cnt == CNT_W'(1));
  assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/out_port_hex_display.sv
`default_nettype none
// ============================================================================
// Module  : out_port_hex_display
// Brief   : Converts three CPU output ports to two-digit decimal 7-seg displays,
//           round-robin sharing one sequential BCD converter.
// Revision: 1.0 - initial release
// ============================================================================
module out_port_hex_display
  import sc_io_pkg::*;
#(
  parameter int BIN_W = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] out_port0,
  input  logic [31:0] out_port1,
  input  logic [31:0] out_port2,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [2:0]  led_ovf,
  output logic        busy
);

  localparam int BCD_W = 4 * bcd_digits(BIN_W);

  state_t            r_state;
  logic [BIN_W-1:0]  r_in_q [NPORTS];
  logic [BIN_W-1:0]  r_last [NPORTS];
  logic [BIN_W-1:0]  r_cap;
  logic [1:0]        r_sel;
  logic [1:0]        r_rr;
  logic [6:0]        r_hex  [2*NPORTS];
  logic [NPORTS-1:0] r_ovf;
  logic              r_busy;

  logic [BIN_W-1:0]  w_port [NPORTS];
  logic [NPORTS-1:0] w_dirty;
  logic              w_any;
  logic [1:0]        w_sel;
  logic              w_start;
  logic              w_done;
  logic [BCD_W-1:0]  w_bcd;
  logic              w_ovf;
  logic              w_unused;

  assign w_port[0] = out_port0[BIN_W-1:0];
  assign w_port[1] = out_port1[BIN_W-1:0];
  assign w_port[2] = out_port2[BIN_W-1:0];
  assign w_unused  = ^{out_port0[31:BIN_W], out_port1[31:BIN_W], out_port2[31:BIN_W]};

  for (genvar p = 0; p < NPORTS; p++) begin : g_dirty
    assign w_dirty[p] = (r_in_q[p] != r_last[p]);
  end

  // Lowest offset from the round-robin pointer wins.
  always_comb begin
    w_any = 1'b0;
    w_sel = r_rr;
    for (int o = NPORTS - 1; o >= 0; o--) begin
      if (w_dirty[2'((int'(r_rr) + o) % NPORTS)]) begin
        w_any = 1'b1;
        w_sel = 2'((int'(r_rr) + o) % NPORTS);
      end
    end
  end

  assign w_start = (r_state == ST_IDLE) && w_any;

  bin2bcd_seq #(
    .BIN_W (BIN_W),
    .BCD_W (BCD_W)
  ) u_bin2bcd (
    .clock  (clock),
    .resetn (resetn),
    .start  (w_start),
    .din    (r_in_q[w_sel]),
    .done   (w_done),
    .bcd    (w_bcd)
  );

  if (BCD_W > 8) begin : g_ovf_hi
    assign w_ovf = |w_bcd[BCD_W-1:8];
  end else begin : g_ovf_none
    assign w_ovf = 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int p = 0; p < NPORTS; p++) begin
        r_in_q[p] <= '0;
        r_last[p] <= '0;
      end
      for (int d = 0; d < 2 * NPORTS; d++) begin
        r_hex[d] <= SEG_ZERO;
      end
      r_state <= ST_IDLE;
      r_cap   <= '0;
      r_sel   <= '0;
      r_rr    <= '0;
      r_ovf   <= '0;
      r_busy  <= 1'b0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        r_in_q[p] <= w_port[p];
      end
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_sel   <= w_sel;
            r_cap   <= r_in_q[w_sel];
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (w_done) begin
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          // Record the converted value, not the live one, so a change during SHIFT re-triggers.
          r_last[r_sel] <= r_cap;
          if (w_ovf) begin
            r_hex[{r_sel, 1'b1}] <= SEG_DASH;
            r_hex[{r_sel, 1'b0}] <= SEG_DASH;
            r_ovf[r_sel]         <= 1'b1;
          end else begin
            r_hex[{r_sel, 1'b1}] <= seg7(w_bcd[7:4]);
            r_hex[{r_sel, 1'b0}] <= seg7(w_bcd[3:0]);
            r_ovf[r_sel]         <= 1'b0;
          end
          r_rr    <= (r_sel == 2'(NPORTS - 1)) ? 2'd0 : r_sel + 2'd1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign hex0    = r_hex[0];
  assign hex1    = r_hex[1];
  assign hex2    = r_hex[2];
  assign hex3    = r_hex[3];
  assign hex4    = r_hex[4];
  assign hex5    = r_hex[5];
  assign led_ovf = r_ovf;
  assign busy    = r_busy;

endmodule
`default_nettype wire
